elevator_car_model: RTL and testbench

- Cycle-accurate model of the elevator car and shaft: the plant on the other end of the controller's motor/direction interface.
- Consumes motor and direction commands. Produces the current-floor index, floor-arrival pulses, door status and sticky safety faults.
- Closes the loop around the elevator controller in simulation. It is also synthesizable, for FPGA demo boards.

---
 rtl/elevator_car_model.sv | 250 +++++++++++++++++++++++++
 tb/tb_elevator_car_model.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_car_model.sv
// ---------------------------------------------------------------------------
// elevator_car_model
//
// Cycle-accurate plant model of an elevator car and shaft. It sits on the far
// side of the controller's motor/direction interface: it consumes motor and
// direction commands and reports the floor the car last reached, one-cycle
// arrival pulses, door status and a sticky safety fault. It is synthesizable
// so the closed loop can also run on an FPGA demo board.
//
// Optional feature macro: CAR_SLOW_START_EN
//   Defined   : the first segment after leaving IDLE (or after a reversal at a
//               floor) takes TRAVEL_CYCLES+SLOW_EXTRA sampled cycles.
//   Undefined : every segment takes TRAVEL_CYCLES cycles.
//
// Ports
//   clk        in   1        system clock, all updates on the rising edge
//   rst        in   1        synchronous active-high reset
//   motor      in   1        1 = drive the car, 0 = stop request
//   direction  in   1        1 = up, 0 = down (only meaningful with motor=1)
//   floor_cur  out  FLOOR_W  index of the last floor reached
//   arrive     out  1        one-cycle pulse when floor_cur changes
//   in_motion  out  1        car between floors or leaving a floor
//   door_open  out  1        door dwell in progress
//   fault      out  1        sticky fault flag, cleared only by rst
//   fault_code out  2        01 overrun, 10 reversal, 11 door interlock
// ---------------------------------------------------------------------------
module elevator_car_model #(
  parameter int NUM_FLOORS    = 5,
  parameter int FLOOR_W       = 5,
  parameter int TRAVEL_CYCLES = 8,
  parameter int DOOR_CYCLES   = 4,
  parameter int START_FLOOR   = 0,
  parameter int SLOW_EXTRA    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               motor,
  input  logic               direction,
  output logic [FLOOR_W-1:0] floor_cur,
  output logic               arrive,
  output logic               in_motion,
  output logic               door_open,
  output logic               fault,
  output logic [1:0]         fault_code
);

  // Counter sized for the longest possible segment even when the slow-start
  // feature is compiled out, so the width never depends on the build option.
  localparam int CNT_W  = $clog2(TRAVEL_CYCLES + SLOW_EXTRA + 1);
  localparam int DOOR_W = $clog2(DOOR_CYCLES + 1);

`ifdef CAR_SLOW_START_EN
  localparam int FIRST_EXTRA = SLOW_EXTRA;
`else
  localparam int FIRST_EXTRA = 0;
`endif

  localparam logic [CNT_W-1:0]   SEG_NORM   = CNT_W'(TRAVEL_CYCLES);
  localparam logic [CNT_W-1:0]   SEG_FIRST  = CNT_W'(TRAVEL_CYCLES + FIRST_EXTRA);
  localparam logic [DOOR_W-1:0]  DOOR_LAST  = DOOR_W'(DOOR_CYCLES - 1);
  localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);
  localparam logic [FLOOR_W-1:0] HOME_FLOOR = FLOOR_W'(START_FLOOR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MOVE,
    S_COAST,
    S_DOOR,
    S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'b00,
    FC_OVERRUN  = 2'b01,
    FC_REVERSAL = 2'b10,
    FC_DOOR     = 2'b11
  } fault_code_e;

  state_e             r_state;
  logic [FLOOR_W-1:0] r_floor;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_dir;
  logic               r_first;
  logic [DOOR_W-1:0]  r_door_cnt;
  logic               r_arrive;
  fault_code_e        r_fault_code;

  state_e             w_state_nxt;
  logic [FLOOR_W-1:0] w_floor_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_dir_nxt;
  logic               w_first_nxt;
  logic [DOOR_W-1:0]  w_door_cnt_nxt;
  logic               w_arrive_nxt;
  fault_code_e        w_fault_code_nxt;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_seg_len;
  logic               w_seg_done;
  logic [FLOOR_W-1:0] w_floor_step;
  logic               w_overrun;

  assign w_cnt_inc    = r_cnt + 1'b1;
  assign w_seg_len    = r_first ? SEG_FIRST : SEG_NORM;
  assign w_seg_done   = (w_cnt_inc == w_seg_len);
  assign w_floor_step = r_dir ? (r_floor + 1'b1) : (r_floor - 1'b1);
  // A new segment requested toward the shaft end would leave 0..NUM_FLOORS-1.
  assign w_overrun    = direction ? (r_floor == TOP_FLOOR) : (r_floor == '0);

  // ---------------------------------------------------------------------------
  // State register (holds the whole datapath alongside the FSM state)
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_floor      <= HOME_FLOOR;
      r_cnt        <= '0;
      r_dir        <= 1'b0;
      r_first      <= 1'b0;
      r_door_cnt   <= '0;
      r_arrive     <= 1'b0;
      r_fault_code <= FC_NONE;
    end else begin
      r_state      <= w_state_nxt;
      r_floor      <= w_floor_nxt;
      r_cnt        <= w_cnt_nxt;
      r_dir        <= w_dir_nxt;
      r_first      <= w_first_nxt;
      r_door_cnt   <= w_door_cnt_nxt;
      r_arrive     <= w_arrive_nxt;
      r_fault_code <= w_fault_code_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Branch order encodes the event priority:
  // fault detection first, then arrival, then door timing.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal gets a hold value first so no path can infer a latch.
    w_state_nxt      = r_state;
    w_floor_nxt      = r_floor;
    w_cnt_nxt        = r_cnt;
    w_dir_nxt        = r_dir;
    w_first_nxt      = r_first;
    w_door_cnt_nxt   = r_door_cnt;
    w_arrive_nxt     = 1'b0;
    w_fault_code_nxt = r_fault_code;

    unique case (r_state)
      S_IDLE: begin
        if (motor) begin
          if (w_overrun) begin
            w_state_nxt      = S_FAULT;
            w_fault_code_nxt = FC_OVERRUN;
          end else begin
            w_state_nxt = S_MOVE;
            w_cnt_nxt   = CNT_W'(1);
            w_dir_nxt   = direction;
            w_first_nxt = 1'b1;
          end
        end
      end

      S_MOVE: begin
        if (r_cnt == '0) begin
          // Parked on a floor right after arrival: stop, continue or reverse.
          if (!motor) begin
            w_state_nxt    = S_DOOR;
            w_door_cnt_nxt = '0;
          end else if (w_overrun) begin
            w_state_nxt      = S_FAULT;
            w_fault_code_nxt = FC_OVERRUN;
          end else begin
            // A reversal restarts the acceleration profile.
            w_first_nxt = (direction != r_dir);
            w_dir_nxt   = direction;
            w_cnt_nxt   = CNT_W'(1);
          end
        end else if (motor && (direction != r_dir)) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_REVERSAL;
        end else if (w_seg_done) begin
          w_floor_nxt  = w_floor_step;
          w_cnt_nxt    = '0;
          w_arrive_nxt = 1'b1;
          if (!motor) begin
            w_state_nxt    = S_DOOR;
            w_door_cnt_nxt = '0;
          end
        end else begin
          // The edge that drops the motor still counts toward the segment.
          w_cnt_nxt = w_cnt_inc;
          if (!motor) begin
            w_state_nxt = S_COAST;
          end
        end
      end

      S_COAST: begin
        // Momentum carries the car to the next floor; commands are ignored.
        if (w_seg_done) begin
          w_floor_nxt    = w_floor_step;
          w_cnt_nxt      = '0;
          w_arrive_nxt   = 1'b1;
          w_state_nxt    = S_DOOR;
          w_door_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      S_DOOR: begin
        if (motor) begin
          w_state_nxt      = S_FAULT;
          w_fault_code_nxt = FC_DOOR;
        end else if (r_door_cnt == DOOR_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_door_cnt_nxt = r_door_cnt + 1'b1;
        end
      end

      S_FAULT: begin
        w_state_nxt = S_FAULT;
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    floor_cur  = r_floor;
    arrive     = r_arrive;
    fault_code = r_fault_code;
    fault      = (r_state == S_FAULT);
    in_motion  = (r_state == S_MOVE) || (r_state == S_COAST);
    // An interlock fault freezes the door in its open position.
    door_open  = (r_state == S_DOOR) ||
                 ((r_state == S_FAULT) && (r_fault_code == FC_DOOR));
  end

endmodule

// File: tb/tb_elevator_car_model.sv
// ---------------------------------------------------------------------------
// tb_elevator_car_model
//
// Drives directed scenarios and a long randomized command stream into
// elevator_car_model. A behavioural model of the car (floor, progress through
// the current segment, remaining door time, fault) predicts every output after
// each clock edge, and a compare process checks the DUT against it. Directed
// scenarios additionally pin key moments with hand-computed literals.
// ---------------------------------------------------------------------------
module tb_elevator_car_model;

  localparam int NUM_FLOORS    = 5;
  localparam int FLOOR_W       = 5;
  localparam int TRAVEL_CYCLES = 8;
  localparam int DOOR_CYCLES   = 4;
  localparam int START_FLOOR   = 0;
  localparam int SLOW_EXTRA    = 4;
`ifdef CAR_SLOW_START_EN
  localparam int FIRST_EXTRA = SLOW_EXTRA;
`else
  localparam int FIRST_EXTRA = 0;
`endif
  // Length of the first segment after leaving a stop or reversing.
  localparam int SEG1 = TRAVEL_CYCLES + FIRST_EXTRA;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               motor = 1'b0;
  logic               direction = 1'b0;
  logic [FLOOR_W-1:0] floor_cur;
  logic               arrive;
  logic               in_motion;
  logic               door_open;
  logic               fault;
  logic [1:0]         fault_code;

  elevator_car_model #(
    .NUM_FLOORS   (NUM_FLOORS),
    .FLOOR_W      (FLOOR_W),
    .TRAVEL_CYCLES(TRAVEL_CYCLES),
    .DOOR_CYCLES  (DOOR_CYCLES),
    .START_FLOOR  (START_FLOOR),
    .SLOW_EXTRA   (SLOW_EXTRA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .motor     (motor),
    .direction (direction),
    .floor_cur (floor_cur),
    .arrive    (arrive),
    .in_motion (in_motion),
    .door_open (door_open),
    .fault     (fault),
    .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the car is either parked, travelling (with a progress
  // count through the current segment and a segment length), dwelling with
  // the door open (remaining cycles), or faulted.
  // ---------------------------------------------------------------------------
  int m_floor;
  int m_code;
  bit m_fault;
  bit m_arrive;
  bit m_moving;
  bit m_coast;
  bit m_dir;
  int m_prog;
  int m_seg;
  int m_door_left;

  function automatic bit leaves_shaft(input int fl, input bit up);
    return up ? (fl == NUM_FLOORS - 1) : (fl == 0);
  endfunction

  task automatic m_finish_segment();
    m_floor  = m_dir ? m_floor + 1 : m_floor - 1;
    m_arrive = 1'b1;
    m_prog   = 0;
    if (m_coast) begin
      m_coast     = 1'b0;
      m_moving    = 1'b0;
      m_door_left = DOOR_CYCLES;
    end
  endtask

  task automatic m_step(input bit r, input bit mo, input bit di);
    m_arrive = 1'b0;
    if (r) begin
      m_floor = START_FLOOR; m_code = 0; m_fault = 0; m_moving = 0;
      m_coast = 0; m_prog = 0; m_door_left = 0; m_dir = 0; m_seg = SEG1;
    end else if (m_fault) begin
      // frozen until reset
    end else if (m_door_left > 0) begin
      if (mo) begin m_fault = 1; m_code = 3; end
      else m_door_left--;
    end else if (!m_moving) begin
      if (mo) begin
        if (leaves_shaft(m_floor, di)) begin m_fault = 1; m_code = 1; end
        else begin m_moving = 1; m_dir = di; m_prog = 1; m_seg = SEG1; end
      end
    end else if (m_coast) begin
      m_prog++;
      if (m_prog == m_seg) m_finish_segment();
    end else if (m_prog == 0) begin
      if (!mo) begin
        m_moving = 0; m_door_left = DOOR_CYCLES;
      end else if (leaves_shaft(m_floor, di)) begin
        m_fault = 1; m_code = 1;
      end else begin
        m_seg  = (di != m_dir) ? SEG1 : TRAVEL_CYCLES;
        m_dir  = di;
        m_prog = 1;
      end
    end else if (mo && (di != m_dir)) begin
      m_fault = 1; m_code = 2;
    end else begin
      m_prog++;
      if (!mo) m_coast = 1;
      if (m_prog == m_seg) m_finish_segment();
    end
  endtask

  // Advance the model on each edge with the sampled inputs, then compare
  // shortly after the edge once the DUT outputs have settled.
  always @(posedge clk) begin
    m_step(rst, motor, direction);
    #1;
    check("floor_cur", int'(floor_cur), m_floor);
    check("arrive",    int'(arrive),    int'(m_arrive));
    check("in_motion", int'(in_motion), int'(m_moving && !m_fault));
    check("door_open", int'(door_open), int'(m_door_left > 0));
    check("fault",     int'(fault),     int'(m_fault));
    check("fault_code", int'(fault_code), m_code);
  end

  // ---------------------------------------------------------------------------
  // Stimulus (inputs change on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic edges(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; motor = 1'b0; direction = 1'b0;
    edges(2);
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst floor", int'(floor_cur), START_FLOOR);
    check("rst outs", int'({arrive, in_motion, door_open, fault, fault_code}), 0);

    // Continuous upward travel across two floors.
    motor = 1'b1; direction = 1'b1;
    edges(SEG1 - 1);
    check("t1 pre-arrive floor", int'(floor_cur), 0);
    check("t1 pre-arrive pulse", int'(arrive), 0);
    check("t1 moving", int'(in_motion), 1);
    edges(1);
    check("t1 floor1", int'(floor_cur), 1);
    check("t1 arrive1", int'(arrive), 1);
    check("t1 moving at floor", int'(in_motion), 1);
    edges(1);
    check("t1 arrive drop", int'(arrive), 0);
    edges(TRAVEL_CYCLES - 1);
    check("t1 floor2", int'(floor_cur), 2);
    check("t1 arrive2", int'(arrive), 1);

    // Motor dropped mid-segment: coast to the floor, then door dwell.
    do_reset();
    motor = 1'b1; direction = 1'b1;
    edges(3);
    motor = 1'b0;
    edges(2);
    check("t2 coasting", int'(in_motion), 1);
    check("t2 coast floor", int'(floor_cur), 0);
    edges(SEG1 - 5);
    check("t2 floor", int'(floor_cur), 1);
    check("t2 arrive", int'(arrive), 1);
    check("t2 door first", int'(door_open), 1);
    check("t2 stopped", int'(in_motion), 0);
    edges(DOOR_CYCLES - 1);
    check("t2 door last", int'(door_open), 1);
    edges(1);
    check("t2 door closed", int'(door_open), 0);
    check("t2 idle", int'(in_motion), 0);

    // Down request at the bottom floor.
    do_reset();
    motor = 1'b1; direction = 1'b0;
    edges(1);
    check("t3 fault", int'(fault), 1);
    check("t3 code", int'(fault_code), 1);
    check("t3 floor", int'(floor_cur), 0);
    direction = 1'b1;
    edges(10);
    check("t3 sticky", int'(fault), 1);
    check("t3 code held", int'(fault_code), 1);
    check("t3 no motion", int'(in_motion), 0);

    // Reversal mid-segment, then a legal reversal at a floor.
    do_reset();
    motor = 1'b1; direction = 1'b1;
    edges(5);
    direction = 1'b0;
    edges(1);
    check("t4 reversal code", int'(fault_code), 2);
    check("t4 reversal floor", int'(floor_cur), 0);
    do_reset();
    motor = 1'b1; direction = 1'b1;
    edges(SEG1);
    direction = 1'b0;
    edges(SEG1);
    check("t4 back at 0", int'(floor_cur), 0);
    check("t4 arrive down", int'(arrive), 1);
    check("t4 no fault", int'(fault), 0);
    edges(1);
    check("t4 bottom overrun", int'(fault_code), 1);

    // Motor request during the second door cycle.
    do_reset();
    motor = 1'b1; direction = 1'b1;
    edges(SEG1);
    motor = 1'b0;
    edges(2);
    check("t5 door 2nd cycle", int'(door_open), 1);
    motor = 1'b1;
    edges(1);
    check("t5 fault", int'(fault), 1);
    check("t5 code", int'(fault_code), 3);
    check("t5 door held", int'(door_open), 1);

    // Reset mid-segment at floor 3, restart, and run into the top floor.
    do_reset();
    motor = 1'b1; direction = 1'b1;
    edges(SEG1 + 2 * TRAVEL_CYCLES + 4);
    check("t6 floor3", int'(floor_cur), 3);
    rst = 1'b1;
    edges(1);
    check("t6 rst floor", int'(floor_cur), START_FLOOR);
    check("t6 rst outs", int'({arrive, in_motion, door_open, fault, fault_code}), 0);
    rst = 1'b0;
    edges(SEG1 - 1);
    check("t6 first seg pending", int'(arrive), 0);
    edges(1);
    check("t6 first arrival", int'(arrive), 1);
    edges(3 * TRAVEL_CYCLES);
    check("t6 top floor", int'(floor_cur), NUM_FLOORS - 1);
    edges(1);
    check("t6 top overrun", int'(fault_code), 1);

    // Randomized command stream with sticky motor and rare direction flips.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      if ($urandom_range(0, 9) == 0) motor = ~motor;
      if ($urandom_range(0, 19) == 0) direction = ~direction;
      edges(1);
    end
    rst = 1'b1;
    edges(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
